multicycle_ctrl: RTL and testbench

- Central control FSM for the multi-cycle CPU datapath.
- Drives the enables that move an instruction through FETCH, DECODE, EXECUTE, MEM and WB: instruction register, PC, operand latch, ALU result latch, register file write and data memory request.
- Replaces ad-hoc sequencing with explicit one-cycle strobes.
- Adds a data-memory wait handshake with a timeout fault.

---
 rtl/cpu_ctrl_pkg.sv | 32 +++
 rtl/mem_wait_timer.sv | 26 ++
 rtl/multicycle_ctrl.sv | 128 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode/state encodings and opcode classification helpers for the
// multi-cycle CPU control unit.
package cpu_ctrl_pkg;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_SW  = 3'b001;
  localparam logic [2:0] OP_BEQ = 3'b010;
  localparam logic [2:0] OP_BLT = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_OR  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6
  } state_t;

  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_alu_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on data memory; expired is high on the
// MEM_TIMEOUT-th consecutive enabled cycle after a clear.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Central FETCH/DECODE/EXECUTE/MEM/WB sequencer for the multi-cycle CPU,
// with a data-memory wait timeout that parks the core in HALT.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [2:0]          opcode,
  input  logic                branch_taken,
  input  logic                dmem_ready,
  output logic                ir_load,
  output logic                pc_inc,
  output logic                pc_load_branch,
  output logic                opnd_latch,
  output logic                alu_latch,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                reg_write,
  output logic                wb_sel,
  output logic                fault,
  output logic [2:0]          state,
  output logic [RETIRE_W-1:0] retired
);

  state_t              state_q, state_d;
  logic [2:0]          op_q;
  logic                fault_q;
  logic [RETIRE_W-1:0] retired_q;
  logic                retire;
  logic                set_fault;
  logic                mem_expired;
  state_t              boundary;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .clear   (state_q != ST_MEM),
    .en      (state_q == ST_MEM),
    .expired (mem_expired)
  );

  always_comb begin
    state_d        = state_q;
    ir_load        = 1'b0;
    pc_inc         = 1'b0;
    pc_load_branch = 1'b0;
    opnd_latch     = 1'b0;
    alu_latch      = 1'b0;
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    reg_write      = 1'b0;
    wb_sel         = 1'b0;
    retire         = 1'b0;
    set_fault      = 1'b0;
    // run is only honoured at an instruction boundary
    boundary       = run ? ST_FETCH : ST_IDLE;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        opnd_latch = 1'b1;
        state_d    = is_mem_op(opcode) ? ST_MEM : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (is_alu_op(op_q)) begin
          alu_latch = 1'b1;
          state_d   = ST_WB;
        end else begin
          pc_load_branch = branch_taken;
          retire         = 1'b1;
          state_d        = boundary;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_SW);
        // a completion on the timeout cycle still counts as success
        if (dmem_ready) begin
          if (op_q == OP_SW) begin
            retire  = 1'b1;
            state_d = boundary;
          end else begin
            state_d = ST_WB;
          end
        end else if (mem_expired) begin
          set_fault = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        wb_sel    = (op_q == OP_LW);
        retire    = 1'b1;
        state_d   = boundary;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (set_fault) fault_q <= 1'b1;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_DECODE) op_q <= opcode;
  end

  assign state   = state_q;
  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction walk-through followed by
// randomized traffic checked each cycle against an instruction-level model.
module tb_multicycle_ctrl;

  localparam int TO = 4;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic [2:0]    opcode = 3'd0;
  logic          branch_taken = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          ir_load, pc_inc, pc_load_branch, opnd_latch, alu_latch;
  logic          dmem_req, dmem_we, reg_write, wb_sel, fault;
  logic [2:0]    state;
  logic [RW-1:0] retired;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Instruction-level model: mode 0 idle, 1 executing, 2 halted.
  // m_k is the cycle index within the current instruction.
  int            m_mode = 0;
  int            m_k = 0;
  int            m_wait = 0;
  bit            m_wb = 1'b0;
  logic [2:0]    m_op = 3'd0;
  logic [RW-1:0] m_ret = '0;
  bit            m_fault = 1'b0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .RETIRE_W(RW)) dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .opcode         (opcode),
    .branch_taken   (branch_taken),
    .dmem_ready     (dmem_ready),
    .ir_load        (ir_load),
    .pc_inc         (pc_inc),
    .pc_load_branch (pc_load_branch),
    .opnd_latch     (opnd_latch),
    .alu_latch      (alu_latch),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .reg_write      (reg_write),
    .wb_sel         (wb_sel),
    .fault          (fault),
    .state          (state),
    .retired        (retired)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      bit ret;
      @(posedge clk);
      ret = 1'b0;
      if (rst) begin
        m_mode = 0; m_ret = '0; m_fault = 1'b0;
      end else if (m_mode == 0) begin
        if (run) begin m_mode = 1; m_k = 0; end
      end else if (m_mode == 1) begin
        if (m_k == 0) m_k = 1;
        else if (m_k == 1) begin
          m_op = opcode; m_k = 2; m_wait = 0; m_wb = 1'b0;
        end else if (m_op == 3'd2 || m_op == 3'd3) ret = 1'b1;
        else if (m_op >= 3'd4) begin
          if (m_k == 2) m_k = 3; else ret = 1'b1;
        end else if (m_wb) ret = 1'b1;
        else if (dmem_ready) begin
          if (m_op == 3'd1) ret = 1'b1; else m_wb = 1'b1;
        end else if (m_wait + 1 >= TO) begin
          m_mode = 2; m_fault = 1'b1;
        end else m_wait++;
        if (ret) begin
          m_ret = m_ret + 1'b1;
          m_mode = run ? 1 : 0;
          m_k = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      logic [8:0] e, g;
      logic [2:0] est;
      @(negedge clk);
      if (check_en) begin
        e = '0; est = 3'd0;
        if (m_mode == 2) est = 3'd6;
        else if (m_mode == 1) begin
          if (m_k == 0) begin est = 3'd1; e[8] = 1'b1; e[7] = 1'b1; end
          else if (m_k == 1) begin est = 3'd2; e[5] = 1'b1; end
          else if (m_op == 3'd2 || m_op == 3'd3) begin est = 3'd3; e[6] = branch_taken; end
          else if (m_op >= 3'd4) begin
            if (m_k == 2) begin est = 3'd3; e[4] = 1'b1; end
            else begin est = 3'd5; e[1] = 1'b1; end
          end else if (m_wb) begin est = 3'd5; e[1] = 1'b1; e[0] = 1'b1; end
          else begin est = 3'd4; e[3] = 1'b1; e[2] = (m_op == 3'd1); end
        end
        g = {ir_load, pc_inc, pc_load_branch, opnd_latch, alu_latch,
             dmem_req, dmem_we, reg_write, wb_sel};
        chk("strobes", 32'(g), 32'(e));
        chk("state", 32'(state), 32'(est));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("retired", 32'(retired), 32'(m_ret));
      end
    end
  end

  task automatic row(input bit r, input bit rn, input logic [2:0] op, input bit bt,
                     input bit rdy, input int est, input int eret, input bit efl);
    rst = r; run = rn; opcode = op; branch_taken = bt; dmem_ready = rdy;
    @(posedge clk);
    #2;
    chk("dir_state", 32'(state), 32'(est));
    chk("dir_retired", 32'(retired), 32'(eret));
    chk("dir_fault", 32'(fault), 32'(efl));
    check_en = 1'b1;
  endtask

  initial begin
    // add: FETCH, DECODE, EXECUTE, WB, retire
    row(1, 0, 3'd0, 0, 0, 0, 0, 0);
    row(0, 1, 3'd4, 0, 0, 1, 0, 0);
    row(0, 1, 3'd4, 0, 0, 2, 0, 0);
    row(0, 1, 3'd4, 0, 0, 3, 0, 0);
    row(0, 1, 3'd0, 1, 1, 5, 0, 0);
    row(0, 1, 3'd0, 0, 0, 1, 1, 0);
    // beq taken with run dropped at retire
    row(0, 1, 3'd7, 0, 0, 2, 1, 0);
    row(0, 1, 3'd2, 0, 0, 3, 1, 0);
    row(0, 0, 3'd0, 1, 0, 0, 2, 0);
    row(0, 0, 3'd0, 0, 0, 0, 2, 0);
    // sw with no completion: timeout into HALT, cleared by rst
    row(0, 1, 3'd0, 0, 0, 1, 2, 0);
    row(0, 1, 3'd0, 0, 0, 2, 2, 0);
    row(0, 1, 3'd1, 0, 0, 4, 2, 0);
    row(0, 1, 3'd0, 0, 0, 4, 2, 0);
    row(0, 1, 3'd0, 0, 0, 4, 2, 0);
    row(0, 1, 3'd0, 0, 0, 4, 2, 0);
    row(0, 1, 3'd0, 0, 0, 6, 2, 1);
    row(0, 1, 3'd0, 0, 1, 6, 2, 1);
    row(1, 1, 3'd0, 0, 0, 0, 0, 0);
    // lw completing on the second MEM cycle
    row(0, 1, 3'd0, 0, 0, 1, 0, 0);
    row(0, 1, 3'd0, 0, 0, 2, 0, 0);
    row(0, 1, 3'd0, 0, 0, 4, 0, 0);
    row(0, 1, 3'd0, 0, 0, 4, 0, 0);
    row(0, 1, 3'd0, 0, 1, 5, 0, 0);
    row(0, 1, 3'd0, 0, 0, 1, 1, 0);
    // rst during MEM of lw
    row(0, 1, 3'd0, 0, 0, 2, 1, 0);
    row(0, 1, 3'd0, 0, 0, 4, 1, 0);
    row(1, 1, 3'd0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      if (m_mode == 2) rst = ($urandom_range(0, 7) == 0);
      else rst = ($urandom_range(0, 49) == 0);
      run = ($urandom_range(0, 7) != 0);
      opcode = 3'($urandom);
      branch_taken = 1'($urandom);
      dmem_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #2;
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
